// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch front end's external traffic: redirect from the back
//   end, the synchronous-read instruction memory port, the issue-side
//   valid/ready handshake and the queue occupancy.
//
//   master : the fetch unit (drives imem_req/imem_addr, out_*, fq_count)
//   slave  : the environment (back end, instruction memory, issue stage)
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    logic [CW-1:0]   fq_count;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, fq_count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, fq_count
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Owns the PC, issues sequential reads to a
//   synchronous-read instruction memory, buffers returned instructions with
//   their PCs in a DEPTH-entry circular queue and drains that queue to issue
//   through a valid/ready handshake. A redirect flushes the queue and cancels
//   the in-flight fetch.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high; wins over redirect
//     bus    : fetch_unit_if.master
//              redirect_valid/redirect_pc  back-end PC change + flush
//              imem_req/imem_addr          read request, address = pc
//              imem_rdata                  read data, one cycle after request
//              out_valid/out_ready         issue handshake for the queue head
//              out_instr/out_pc            head entry (0 when empty)
//              fq_count                    queue occupancy
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int          INSTR_BYTES = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;

    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [CW:0]     credits_used;
    logic            flush;
    logic            req;
    logic            enq;
    logic            deq;

    // -----------------------------------------------------------------------
    // Request stage: credit check against registered state only, so a
    // dequeue in this same cycle never frees a slot for this request.
    // -----------------------------------------------------------------------
    always_comb begin
        flush        = reset || bus.redirect_valid;
        credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
        req          = !flush && (credits_used < (CW+1)'(DEPTH));
        enq          = inflight && !flush;
        deq          = bus.out_valid && bus.out_ready;
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.fq_count  = count;
    assign bus.out_valid = (count != '0) && !bus.redirect_valid;
    assign bus.out_instr = (count != '0) ? q_instr[head] : '0;
    assign bus.out_pc    = (count != '0) ? q_pc[head]    : '0;

    // -----------------------------------------------------------------------
    // Control state: PC, in-flight flag, queue pointers and occupancy.
    // Reset beats redirect; both squash the response arriving next cycle by
    // clearing inflight.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (req) begin
                pc <= pc + XLEN'(INSTR_BYTES);
            end
            inflight <= req;
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Response stage: data path is not reset; the pointers and inflight flag
    // decide what is live.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (req) begin
            inflight_pc <= pc;
        end
        if (enq) begin
            q_instr[tail] <= bus.imem_rdata;
            q_pc[tail]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_ent_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_pops;
    logic [31:0] mem_xor;
    logic [31:0] exp_fetch_pc;
    sb_ent_t     sb[$];

    fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .INSTR_BYTES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_xor;
    endfunction

    // Synchronous-read memory; junk on cycles without a request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
        else              bus.imem_rdata <= 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input int n, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.fq_count == n) break;
            tick();
        end
        check(tag, 32'(bus.fq_count), n);
    endtask

    // Scoreboard: expected entries pushed as each request is issued,
    // popped and compared on every accepted issue handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req", 32'(bus.imem_req), 0);
            sb.delete();
            exp_fetch_pc = 32'h0;
        end else if (bus.redirect_valid) begin
            check("redir_req", 32'(bus.imem_req), 0);
            check("redir_valid", 32'(bus.out_valid), 0);
            sb.delete();
            exp_fetch_pc = bus.redirect_pc;
        end else begin
            if (bus.imem_req) begin
                sb_ent_t e;
                check("imem_addr", bus.imem_addr, exp_fetch_pc);
                e.pc    = exp_fetch_pc;
                e.instr = mem_word(exp_fetch_pc);
                sb.push_back(e);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", bus.out_pc, 32'hFFFF_FFFF);
                end else begin
                    sb_ent_t e;
                    e = sb.pop_front();
                    check("out_pc", bus.out_pc, e.pc);
                    check("out_instr", bus.out_instr, e.instr);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        int p0;
        n_checks = 0;
        n_errors = 0;
        n_pops   = 0;
        mem_xor  = 32'h0;
        exp_fetch_pc = 32'h0;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;
        tick();
        tick();
        check("rst_count", 32'(bus.fq_count), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_instr", bus.out_instr, 0);
        check("rst_pc", bus.out_pc, 0);
        check("rst_addr", bus.imem_addr, 0);

        // Sequential fetch with word = address, issue always ready.
        reset = 1'b0;
        #1;
        check("first_req", 32'(bus.imem_req), 1);
        check("lat_c0", 32'(bus.out_valid), 0);
        tick();
        check("lat_c1", 32'(bus.out_valid), 0);
        tick();
        check("lat_c2", 32'(bus.out_valid), 1);
        check("first_pc", bus.out_pc, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("thruput", 32'(bus.out_valid), 1);
        end

        // Stall: refetch from 0 with a scrambled memory, issue blocked.
        mem_xor = 32'hA5A5_0000;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("full_count", 32'(bus.fq_count), 4);
        check("full_req", 32'(bus.imem_req), 0);
        check("full_head_pc", bus.out_pc, 0);
        check("full_head_instr", bus.out_instr, 32'hA5A5_0000);
        p0 = n_pops;
        bus.out_ready = 1'b1;
        tick();
        check("drain_count", 32'(bus.fq_count), 3);
        for (int i = 0; i < 4; i++) tick();
        check("drain_pops", 32'(n_pops - p0 >= 4), 1);

        // Redirect to 0x100 with two queued and one in flight.
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        wait_count(2, "wait_q2");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        #1;
        check("redir_outv", 32'(bus.out_valid), 0);
        tick();
        bus.redirect_valid = 1'b0;
        check("redir_flush", 32'(bus.fq_count), 0);
        check("redir_addr", bus.imem_addr, 32'h100);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("redir_head", bus.out_pc, 32'h100);
        for (int i = 0; i < 4; i++) tick();

        // PC wrap.
        p0 = n_pops;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("wrap_pops", 32'(n_pops - p0 >= 4), 1);

        // Reset and redirect together: reset wins.
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        check("rr_addr", bus.imem_addr, 32'h0);
        check("rr_count", 32'(bus.fq_count), 0);
        check("rr_valid", 32'(bus.out_valid), 0);

        // Reset mid-stream with three queued and one in flight.
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        wait_count(3, "wait_q3");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_count", 32'(bus.fq_count), 0);
        check("mr_valid", 32'(bus.out_valid), 0);
        check("mr_addr", bus.imem_addr, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("mr_head_pc", bus.out_pc, 32'h0);
        check("mr_head_instr", bus.out_instr, 32'hA5A5_0000);
        for (int i = 0; i < 6; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
